lock_ctrl: RTL

Password-lock controller that sits directly downstream of the keypad scanner. It consumes the scanner's one-cycle key strobe and 4-bit key code, and assembles digit entries. It compares each entry with a stored code and drives the unlock and alarm outputs. It also supports changing the code while the lock is open, and enforces a lockout after repeated failed attempts.

---
 rtl/lock_pkg.sv | 15 +
 rtl/lock_timer.sv | 31 +++
 rtl/lock_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared key codes and FSM state encoding for the password-lock controller.
package lock_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    SET     = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock and lockout intervals.
module lock_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  // Single-cycle pulse: busy drops on the cycle after the count hits zero.
  assign done = busy && (cnt == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Password-lock controller: assembles keypad digits, checks them against a
// stored code, and drives unlock/alarm with code change and lockout support.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 250_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_flag,
  input  logic [3:0] key_value,
  output logic       unlock,
  output logic       alarm,
  output logic       err_pulse,
  output logic       set_mode,
  output logic [2:0] digit_cnt,
  output logic [2:0] state
);

  localparam int BUF_W = 4 * CODE_LEN;
  localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]  CODE_LEN_C   = 4'(CODE_LEN);
  localparam logic [3:0]  MAX_TRIES_C  = 4'(MAX_TRIES);

  state_t           st;
  logic [BUF_W-1:0] entry_buf;
  logic [BUF_W-1:0] code;
  logic [3:0]       cnt;
  logic [3:0]       tries;

  logic        is_digit, is_star, is_hash;
  logic        buf_full, match, last_try;
  logic        timer_load, timer_busy, timer_done;
  logic [31:0] timer_val;
  logic [3:0]  tries_inc;

  assign is_digit  = key_flag && (key_value <= 4'd9);
  assign is_star   = key_flag && (key_value == KEY_STAR);
  assign is_hash   = key_flag && (key_value == KEY_HASH);
  assign buf_full  = (cnt == CODE_LEN_C);
  assign match     = buf_full && (entry_buf == code);
  assign tries_inc = tries + 4'd1;
  assign last_try  = (tries_inc == MAX_TRIES_C);

  // The timer is armed only from CHECK, with the interval of the state being entered.
  assign timer_load = (st == CHECK) && (match || last_try);
  assign timer_val  = match ? UNLOCK_LOAD : LOCKOUT_LOAD;

  lock_timer #(.W(32)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .busy     (timer_busy),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ENTRY;
      entry_buf <= '0;
      cnt       <= '0;
      code      <= DEFAULT_CODE;
      tries     <= '0;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      err_pulse <= 1'b0;
      set_mode  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (st)
        ENTRY, SET: begin
          if (is_digit && !buf_full) begin
            entry_buf <= (entry_buf << 4) | BUF_W'(key_value);
            cnt       <= cnt + 4'd1;
          end else if (is_star) begin
            entry_buf <= '0;
            cnt       <= '0;
          end else if (is_hash) begin
            if (st == ENTRY) begin
              st <= CHECK;
            end else begin
              entry_buf <= '0;
              cnt       <= '0;
              if (buf_full) begin
                code     <= entry_buf;
                set_mode <= 1'b0;
                st       <= ENTRY;
              end else begin
                err_pulse <= 1'b1;
              end
            end
          end
        end
        CHECK: begin
          entry_buf <= '0;
          cnt       <= '0;
          if (match) begin
            tries  <= '0;
            unlock <= 1'b1;
            st     <= OPEN;
          end else begin
            err_pulse <= 1'b1;
            tries     <= tries_inc;
            if (last_try) begin
              alarm <= 1'b1;
              st    <= LOCKOUT;
            end else begin
              st <= ENTRY;
            end
          end
        end
        OPEN: begin
          // Expiry wins over a simultaneous '#'.
          if (timer_done || !timer_busy) begin
            unlock <= 1'b0;
            st     <= ENTRY;
          end else if (is_hash) begin
            unlock   <= 1'b0;
            set_mode <= 1'b1;
            st       <= SET;
          end
        end
        LOCKOUT: begin
          if (timer_done || !timer_busy) begin
            alarm <= 1'b0;
            tries <= '0;
            st    <= ENTRY;
          end
        end
        default: begin
          st <= ENTRY;
        end
      endcase
    end
  end

  // A full 8-digit buffer cannot be shown on the 3-bit port; it reads as 7.
  assign digit_cnt = (cnt > 4'd7) ? 3'd7 : cnt[2:0];
  assign state     = st;

endmodule
